// File: rtl/dmem_cache_pkg.sv
// Shared geometry and FSM encoding for the MEM-stage data cache.
// Address layout: [tag | index | word select | byte offset].
package dmem_cache_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LINES   = 64;
  localparam int WPL     = 4;
  localparam int WSEL_W  = 2;
  localparam int OFF_W   = 4;
  localparam int IDX_W   = $clog2(LINES);
  localparam int IDX_LSB = OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam int LINE_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_cache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous write, synchronous valid clear.
// Tag and data contents survive clear; only the valid bits are dropped.
module dmem_cache_array
  import dmem_cache_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WSEL_W-1:0] rd_wsel,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WSEL_W-1:0] wr_wsel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WPL];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_wsel}];

  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx] <= fill_tag;
    end
    if (wr_en) begin
      data_mem[{wr_idx, wr_wsel}] <= wr_data;
    end
  end

endmodule

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Loads hit in zero cycles; misses refill a 4-word line; stores always go to memory.
module dmem_cache
  import dmem_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  state_t            state;
  logic [WSEL_W-1:0] cnt;
  logic              served;
  logic [LINE_W-1:0] lat_line;

  logic              is_wr, is_rd, hit, ack_ok, refill_ack;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en, fill_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [WSEL_W-1:0] wr_wsel;
  logic [DATA_W-1:0] wr_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];
  assign dbg_state        = state;

  // A store wins when both commands are raised together.
  assign is_wr = cpu_wr;
  assign is_rd = cpu_rd & ~cpu_wr;
  assign hit   = rd_valid && (rd_tag == cpu_addr[ADDR_W-1:TAG_LSB]);

  // Memory side: mem_req is a valid held until a one-cycle mem_ack completes it.
  // An ack only counts while a request is actually outstanding.
  assign ack_ok     = mem_ack && mem_req && (state != ST_IDLE);
  assign refill_ack = ack_ok && (state == ST_REFILL);

  always_comb begin
    stall     = 1'b1;
    cpu_rdata = '0;
    if (state == ST_IDLE) begin
      if (served) begin
        stall = 1'b0;
      end else if (is_wr) begin
        stall = 1'b1;
      end else if (is_rd) begin
        stall = ~hit;
      end else begin
        stall = 1'b0;
      end
      if (is_rd && hit) cpu_rdata = rd_data;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cpu_addr[TAG_LSB-1:IDX_LSB];
    wr_wsel = cpu_addr[OFF_W-1:2];
    wr_data = cpu_wdata;
    if (!reset) begin
      if (refill_ack) begin
        wr_en   = 1'b1;
        wr_idx  = lat_line[IDX_W-1:0];
        wr_wsel = cnt;
        wr_data = mem_rdata;
      end else if (state == ST_IDLE && is_wr && !served && hit) begin
        wr_en = 1'b1;
      end
    end
  end

  assign fill_en = !reset && refill_ack && (cnt == WSEL_W'(WPL-1));

  dmem_cache_array u_array (
    .clk      (clk),
    .clear    (reset),
    .rd_idx   (cpu_addr[TAG_LSB-1:IDX_LSB]),
    .rd_wsel  (cpu_addr[OFF_W-1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_wsel  (wr_wsel),
    .wr_data  (wr_data),
    .fill_en  (fill_en),
    .fill_idx (lat_line[IDX_W-1:0]),
    .fill_tag (lat_line[LINE_W-1:IDX_W])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      served    <= 1'b0;
      lat_line  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          served <= 1'b0;
          if (!served && is_wr) begin
            state     <= ST_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= cpu_wdata;
          end else if (!served && is_rd && !hit) begin
            state    <= ST_REFILL;
            cnt      <= '0;
            lat_line <= cpu_addr[ADDR_W-1:OFF_W];
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        ST_REFILL: begin
          // One read outstanding at a time, with a dead cycle after every ack.
          if (ack_ok) begin
            mem_req <= 1'b0;
            cnt     <= cnt + 1'b1;
            if (cnt == WSEL_W'(WPL-1)) state <= ST_IDLE;
          end else if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {lat_line, cnt, 2'b00};
          end
        end
        ST_WRITE: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            served  <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_cache.sv
// Randomised scoreboard bench for dmem_cache with a behavioural memory/cache model.
// Drivers push expected loads and memory transactions; one monitor pops and compares.
module tb_dmem_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  dbg_state;

  dmem_cache dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic rst_q = 1'b0;
  always @(posedge clk) rst_q <= reset;

  // ---------------- shared state ----------------
  logic [33:0] exp_q[$];      // {is_store, expect_hit, load_data}
  logic [64:0] exp_mem_q[$];  // {we, word_addr, write_data}
  logic [31:0] bmem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [27:0] ref_line [int];
  int  checks = 0;
  int  errors = 0;
  int  lat_fixed = 3;
  bit  spur_en = 1'b0;
  bit  done = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // ---------------- backing memory responder ----------------
  initial begin : responder
    logic [31:0] a, d;
    logic        we;
    int          lat;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        a   = mem_addr;
        d   = mem_wdata;
        we  = mem_we;
        lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 7));
        repeat (lat) begin @(posedge clk); #1; end
        if (we) bmem[a] = d;
        else mem_rdata = bmem.exists(a) ? bmem[a] : init_word(a);
        mem_ack = 1'b1;
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        mem_rdata = $urandom;
        mem_ack   = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic finish_op();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (!stall) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    if (!ok) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [31:0] a);
    logic [31:0] wa;
    logic [27:0] line;
    int          idx;
    bit          hit;
    wa   = a & 32'hFFFF_FFFC;
    line = 28'(a >> 4);
    idx  = int'(line % 64);
    hit  = ref_line.exists(idx) && (ref_line[idx] == line);
    if (!hit) begin
      for (int w = 0; w < 4; w++) exp_mem_q.push_back({1'b0, line, 2'(w), 2'b00, 32'h0});
      ref_line[idx] = line;
    end
    exp_q.push_back({1'b0, hit, ref_rd(wa)});
    cpu_rd   = 1'b1;
    cpu_addr = a;
    finish_op();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    exp_mem_q.push_back({1'b1, wa, d});
    ref_mem[wa] = d;
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    cpu_wr    = 1'b1;
    cpu_rd    = both;
    cpu_addr  = a;
    cpu_wdata = d;
    finish_op();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ref_line.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n;
    logic [31:0] a;
    int op;
    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    do_reset();

    // cold miss then hit in the refilled line
    do_load(32'h100);
    do_load(32'h104);
    // write-through hit, then read back
    do_store(32'h104, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h104);
    // store miss does not allocate
    do_store(32'h2000, 32'h1234_5678, 1'b0);
    do_load(32'h2000);
    // conflict eviction at index 16
    do_reset();
    do_load(32'h100);
    do_load(32'h500);
    do_load(32'h100);

    // reset in the middle of a refill
    do_reset();
    exp_mem_q.push_back({1'b0, 32'h100, 32'h0});
    exp_mem_q.push_back({1'b0, 32'h104, 32'h0});
    cpu_rd = 1'b1; cpu_addr = 32'h100;
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(negedge clk);
      if (mem_ack && mem_req) n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    @(posedge clk); #1;
    reset = 1'b1; cpu_rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    ref_line.delete();
    do_load(32'h100);

    // randomised traffic with spurious acks and variable latency
    spur_en   = 1'b1;
    lat_fixed = -1;
    for (int i = 0; i < 100; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      op = int'($urandom_range(0, 99));
      if (op < 55) do_load(a);
      else do_store(a, $urandom, op >= 95);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    repeat (20) @(posedge clk);
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int          stall_cnt;
    logic [33:0] e;
    logic [64:0] m;
    stall_cnt = 0;
    while (!done) begin
      @(negedge clk);
      if (rst_q) begin
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || dbg_state !== 2'd0) begin
          errors++;
          $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h state=%0d, required all 0",
                   mem_req, mem_we, mem_addr, mem_wdata, dbg_state);
        end
        if (!cpu_rd && !cpu_wr) begin
          checks++;
          if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b rdata=%h, required 0/0", stall, cpu_rdata);
          end
        end
      end
      if (mem_ack && mem_req) begin
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem_txn: we=%b addr=%h, required none", mem_we, mem_addr);
        end else begin
          m = exp_mem_q.pop_front();
          if (mem_we !== m[64] || mem_addr !== m[63:32] || (m[64] && mem_wdata !== m[31:0])) begin
            errors++;
            $display("FAIL mem_txn: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                     mem_we, mem_addr, mem_wdata, m[64], m[63:32], m[31:0]);
          end
        end
      end
      if (reset || rst_q || !(cpu_rd || cpu_wr)) begin
        stall_cnt = 0;
      end else if (stall) begin
        stall_cnt++;
        if (stall_cnt == 100) begin
          checks++;
          errors++;
          $display("FAIL stall_timeout: stalled %0d cycles, required < 100", stall_cnt);
        end
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_completion: addr=%h, required no operation", cpu_addr);
        end else begin
          e = exp_q.pop_front();
          if (e[33]) begin
            if (stall_cnt < 2) begin
              errors++;
              $display("FAIL store_stall: %0d stall cycles, required >= 2", stall_cnt);
            end
          end else begin
            if (cpu_rdata !== e[31:0]) begin
              errors++;
              $display("FAIL load_data: addr=%h got %h, required %h", cpu_addr, cpu_rdata, e[31:0]);
            end
            checks++;
            if (e[32] ? (stall_cnt != 0) : (stall_cnt < 8)) begin
              errors++;
              $display("FAIL load_stall: addr=%h hit=%b got %0d stall cycles, required %s",
                       cpu_addr, e[32], stall_cnt, e[32] ? "0" : ">= 8");
            end
          end
        end
        stall_cnt = 0;
      end
    end
    checks++;
    if (exp_q.size() != 0 || exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: %0d ops and %0d mem txns left, required 0/0",
               exp_q.size(), exp_mem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
